// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ecp5pll dynamic phase-shift controller.
// Channel indices use wrapper numbering; the ecp5pll wrapper remaps to PLL pins.
package ecp5pll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef logic [1:0] ch_t;

    localparam ch_t CH_CLKOP  = 2'd0;
    localparam ch_t CH_CLKOS  = 2'd1;
    localparam ch_t CH_CLKOS2 = 2'd2;
    localparam ch_t CH_CLKOS3 = 2'd3;

    localparam int NUM_CH = 4;

endpackage

// File: rtl/ecp5pll_phase_ctrl.sv
// Dynamic phase-shift initiator: sequences phasesel/phasedir setup, step/load
// pulses and hold gaps, and tracks a wrapping step position per output.
module ecp5pll_phase_ctrl
    import ecp5pll_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int POS_W     = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_sel,
    input  logic                      req_dir,
    input  logic                      req_load,
    input  logic [7:0]                req_steps,
    output logic                      done,
    output logic                      busy,
    output logic [NUM_CH*POS_W-1:0]   pos_o,
    output logic [1:0]                phasesel,
    output logic                      phasedir,
    output logic                      phasestep,
    output logic                      phaseloadreg
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [7:0]                     r_tmr;
    logic [7:0]                     w_tmr_nxt;
    logic [7:0]                     r_rem;
    logic [7:0]                     w_rem_nxt;
    logic                           r_load;
    logic                           w_load_nxt;
    ch_t                            r_sel;
    ch_t                            w_sel_nxt;
    logic                           r_dir;
    logic                           w_dir_nxt;
    logic                           r_ready;
    logic                           w_ready_nxt;
    logic                           r_done;
    logic                           w_done_nxt;
    logic                           r_busy;
    logic                           w_busy_nxt;
    logic                           r_step;
    logic                           w_step_nxt;
    logic                           r_ldreg;
    logic                           w_ldreg_nxt;
    logic [NUM_CH-1:0][POS_W-1:0]   r_pos;
    logic [NUM_CH-1:0][POS_W-1:0]   w_pos_nxt;

    logic                           w_accept;
    logic                           w_zero_req;
    logic                           w_tmr_zero;
    logic                           w_pulse_end;

    assign w_accept    = req_valid & r_ready;
    assign w_zero_req  = ~req_load & (req_steps == 8'd0);
    assign w_tmr_zero  = (r_tmr == 8'd0);
    assign w_pulse_end = (r_state == PULSE) & w_tmr_zero;

    // State register; every output is a flop so the PLL pins never see req_* directly.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tmr   <= 8'd0;
            r_rem   <= 8'd0;
            r_load  <= 1'b0;
            r_sel   <= CH_CLKOP;
            r_dir   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
            r_ldreg <= 1'b0;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_rem   <= w_rem_nxt;
            r_load  <= w_load_nxt;
            r_sel   <= w_sel_nxt;
            r_dir   <= w_dir_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_step  <= w_step_nxt;
            r_ldreg <= w_ldreg_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_zero_req) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (w_tmr_zero) begin
                    w_state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_tmr_zero) begin
                    w_state_nxt = (r_rem != 8'd0) ? PULSE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tmr_nxt  = w_tmr_zero ? 8'd0 : r_tmr - 8'd1;
        w_rem_nxt  = r_rem;
        w_load_nxt = r_load;
        w_sel_nxt  = r_sel;
        w_dir_nxt  = r_dir;
        w_pos_nxt  = r_pos;
        w_done_nxt = 1'b0;

        // The shared timer is reloaded for whichever phase is being entered.
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sel_nxt  = req_sel;
                    w_dir_nxt  = req_dir;
                    w_load_nxt = req_load;
                    w_rem_nxt  = req_load ? 8'd1 : req_steps;
                    w_tmr_nxt  = SETUP_LD;
                    w_done_nxt = w_zero_req;
                end
            end
            SETUP: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt = PULSE_LD;
                end
            end
            PULSE: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt = HOLD_LD;
                    w_rem_nxt = r_rem - 8'd1;
                end
            end
            HOLD: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt  = PULSE_LD;
                    w_done_nxt = (r_rem == 8'd0);
                end
            end
            default: ;
        endcase

        // Position moves on the falling edge of each pulse, wrapping modulo 2^POS_W.
        if (w_pulse_end) begin
            if (r_load) begin
                w_pos_nxt[r_sel] = '0;
            end else if (r_dir) begin
                w_pos_nxt[r_sel] = r_pos[r_sel] - POS_W'(1);
            end else begin
                w_pos_nxt[r_sel] = r_pos[r_sel] + POS_W'(1);
            end
        end

        w_ready_nxt = (w_state_nxt == IDLE);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_step_nxt  = (w_state_nxt == PULSE) & ~r_load;
        w_ldreg_nxt = (w_state_nxt == PULSE) &  r_load;
    end

    assign req_ready    = r_ready;
    assign done         = r_done;
    assign busy         = r_busy;
    assign pos_o        = r_pos;
    assign phasesel     = r_sel;
    assign phasedir     = r_dir;
    assign phasestep    = r_step;
    assign phaseloadreg = r_ldreg;

endmodule
